// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with occupancy count, threshold flags and error pulses
module param_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int AF_THRESH  = 480,
  parameter int AE_THRESH  = 32,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_acc, wr_acc;

  always_comb begin
    rd_acc     = rd_en & ~empty_q;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc     = wr_en & (~full_q | rd_acc);
    wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_data_d  = rd_acc ? mem[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_acc;
    ovf_d      = wr_en & ~wr_acc;
    udf_d      = rd_en & ~rd_acc;
    count_d    = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flags are computed from the next count so they register alongside it.
    full_d  = (count_d == CW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_THRESH));
    ae_d    = (count_d <= CW'(AE_THRESH));
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench for param_sync_fifo against a queue reference model
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int checks = 0;
  int passed = 0;

  param_sync_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue plus the last popped word and the pulse outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd = '0;
  logic          m_ovf = 1'b0, m_udf = 1'b0, m_rv = 1'b0;

  wire [10:0] dut_status = {count, full, empty, almost_full, almost_empty, overflow, underflow, rd_valid};

  function automatic logic [10:0] exp_status();
    int n = mq.size();
    return {4'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf, m_rv};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
    bit racc, wacc;
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    racc = r && (mq.size() != 0);
    wacc = w && ((mq.size() != DEPTH) || racc);
    if (racc) m_rd = mq.pop_front();
    if (wacc) mq.push_back(d);
    m_rv = racc; m_ovf = w && !wacc; m_udf = r && !racc;
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (dut_status !== 11'b0000_0101_000) $display("FAIL reset_status actual=%b required=%b", dut_status, 11'b0000_0101_000);
    else passed++;
    checks++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data actual=%h required=00", rd_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 1'b0);
      checks++;
      if (dut_status !== exp_status() || count !== 4'(i + 1))
        $display("FAIL fill_status[%0d] actual=%b required=%b", i, dut_status, exp_status());
      else passed++;
    end
    checks++;
    if (full !== 1'b1 || almost_full !== 1'b1) $display("FAIL fill_full actual=%b%b required=11", full, almost_full);
    else passed++;
  endtask

  task automatic test_overflow();
    drive(1'b1, 8'h99, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) $display("FAIL ovf_pulse actual=%b/%0d required=1/8", overflow, count);
    else passed++;
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear actual=%b required=0", overflow);
    else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (rd_data !== 8'h11 + 8'(i) || dut_status !== exp_status())
        $display("FAIL ovf_drain[%0d] actual=%h/%b required=%h/%b", i, rd_data, dut_status, 8'h11 + 8'(i), exp_status());
      else passed++;
    end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] want;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h11 + 8'(i), 1'b0);
    drive(1'b1, 8'hAA, 1'b1);
    checks++;
    if (rd_data !== 8'h11 || count !== 4'd8 || overflow !== 1'b0 || rd_valid !== 1'b1)
      $display("FAIL full_rw actual=%h/%0d/%b required=11/8/0", rd_data, count, overflow);
    else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      want = (i == DEPTH - 1) ? 8'hAA : 8'h12 + 8'(i);
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (rd_data !== want || dut_status !== exp_status())
        $display("FAIL wrap_drain[%0d] actual=%h required=%h", i, rd_data, want);
      else passed++;
    end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 8'h5C, 1'b1);
    checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 4'd1)
      $display("FAIL empty_rw actual=%b/%b/%0d required=1/0/1", underflow, rd_valid, count);
    else passed++;
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h5C || underflow !== 1'b0 || rd_valid !== 1'b1)
      $display("FAIL empty_rw_read actual=%h required=5c", rd_data);
    else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || almost_empty !== 1'b1)
      $display("FAIL async_reset actual=%b/%0d required=1/0", empty, count);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h77 || dut_status !== exp_status())
      $display("FAIL reset_reuse actual=%h required=77", rd_data);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    int wp, rp;
    for (int i = 0; i < 5000; i++) begin
      case ((i / 250) % 3)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 30; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      drive($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp);
      checks++;
      if (dut_status !== exp_status() || rd_data !== m_rd) begin
        if (errs < 10)
          $display("FAIL random[%0d] actual=%b/%h required=%b/%h", i, dut_status, rd_data, exp_status(), m_rd);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
